// File: rtl/stream_decrypter.sv
// Streaming word decrypter: valid/ready input, loadable key, DEPTH-entry output FIFO.
// Ports: clk, reset (sync, active-high), key_load/key_in/key_valid,
//   in_valid/in_data/in_ready, out_valid/out_data/out_ready,
//   fill_level (0..DEPTH), word_count (accepted words, wraps).
// Optional: define KEY_ROLL_EN to rotate the key left by 1 after every accept.
module stream_decrypter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_load,
  input  logic [WIDTH-1:0]         key_in,
  output logic                     key_valid,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [CNT_W-1:0]         word_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam int NG = WIDTH / 2 - 1;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  typedef enum logic {
    NOKEY,
    KEYED
  } keyState_t;

  keyState_t keyStateQ;
  keyState_t keyStateD;

  logic [WIDTH-1:0] keyReg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [FW-1:0]    count;
  logic [WIDTH-1:0] plain;
  logic [WIDTH-1:0] x;
  logic             accept;
  logic             pop;

  // Key presence: once loaded, only reset takes it away.
  always_ff @(posedge clk) begin
    if (reset) keyStateQ <= NOKEY;
    else       keyStateQ <= keyStateD;
  end

  always_comb begin
    keyStateD = keyStateQ;
    unique case (keyStateQ)
      NOKEY:   if (key_load) keyStateD = KEYED;
      KEYED:   keyStateD = KEYED;
      default: keyStateD = NOKEY;
    endcase
  end

  assign key_valid  = (keyStateQ == KEYED);
  assign in_ready   = key_valid && (count != FULL);
  assign out_valid  = (count != '0);
  assign out_data   = mem[rdPtr];
  assign fill_level = count;
  assign accept     = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  // Even bits inverted, odd bits below the MSB rotated one place up,
  // MSB passed through raw from the cipher word.
  always_comb begin
    x        = in_data ^ keyReg;
    plain    = '0;
    for (int i = 0; i < WIDTH / 2; i++)
      plain[2*i] = ~x[2*i];
    plain[1] = x[2*NG-1];
    for (int j = 1; j < NG; j++)
      plain[2*j+1] = x[2*j-1];
    plain[WIDTH-1] = in_data[WIDTH-1];
  end

  // A same-cycle key_load wins; the accepted word already used the old key.
  always_ff @(posedge clk) begin
    if (reset) begin
      keyReg <= '0;
    end else if (key_load) begin
      keyReg <= key_in;
`ifdef KEY_ROLL_EN
    end else if (accept) begin
      keyReg <= {keyReg[WIDTH-2:0], keyReg[WIDTH-1]};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wrPtr] <= plain;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      word_count <= '0;
    end else begin
      if (accept) begin
        wrPtr      <= wrPtr + 1'b1;
        word_count <= word_count + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_decrypter.sv
// Bench for stream_decrypter (WIDTH=8, DEPTH=4): queue model plus directed vectors.
// Honours KEY_ROLL_EN the same way the design does.
module tb_stream_decrypter;

  localparam int W = 8;
  localparam int D = 4;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_load;
  logic [W-1:0] key_in;
  logic         key_valid;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [2:0]   fill_level;
  logic [C-1:0] word_count;

  int nChecks = 0;
  int nFail   = 0;
  bit started = 0;

  logic [W-1:0] mQ[$];
  logic [W-1:0] mKey   = '0;
  bit           mKeyOk = 0;
  logic [C-1:0] mCount = '0;

  stream_decrypter #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clk(clk), .reset(reset),
    .key_load(key_load), .key_in(key_in), .key_valid(key_valid),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fill_level(fill_level), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decrypt from the rules: invert even bits, rotate the odd-bit group
  // (bits 1,3,5) left by one position, keep the raw cipher MSB.
  function automatic logic [W-1:0] mDec(logic [W-1:0] c, logic [W-1:0] k);
    logic [W-1:0] xx;
    logic [W-1:0] d;
    bit g[3];
    xx = c ^ k;
    d  = '0;
    for (int j = 0; j < 3; j++) g[j] = xx[2*j+1];
    for (int i = 0; i < 4; i++) d[2*i] = !xx[2*i];
    for (int j = 0; j < 3; j++) d[2*j+1] = g[(j + 2) % 3];
    d[7] = c[7];
    return d;
  endfunction

  always @(posedge clk) begin
    bit acc;
    bit pp;
    if (reset) begin
      mQ.delete();
      mKey   = '0;
      mKeyOk = 0;
      mCount = '0;
    end else begin
      acc = in_valid && mKeyOk && (mQ.size() < D);
      pp  = (mQ.size() > 0) && out_ready;
      if (pp) void'(mQ.pop_front());
      if (acc) begin
        mQ.push_back(mDec(in_data, mKey));
        mCount++;
      end
      if (key_load) begin
        mKey   = key_in;
        mKeyOk = 1;
      end
`ifdef KEY_ROLL_EN
      else if (acc) mKey = {mKey[W-2:0], mKey[W-1]};
`endif
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("key_valid", key_valid, mKeyOk);
      chk("in_ready", in_ready, mKeyOk && (mQ.size() < D));
      chk("out_valid", out_valid, mQ.size() != 0);
      if (mQ.size() != 0) chk("out_data", out_data, mQ[0]);
      chk("fill_level", fill_level, mQ.size());
      chk("word_count", word_count, mCount);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp2;
    reset = 1; key_load = 0; key_in = '0;
    in_valid = 0; in_data = '0; out_ready = 0;
    step(); step();
    reset = 0;
    started = 1;

    // No key yet: input must be refused.
    in_valid = 1; in_data = 8'h55;
    @(negedge clk);
    chk("nokey_ready", in_ready, 0);
    step();
    @(negedge clk);
    chk("nokey_fill", fill_level, 0);
    chk("nokey_cnt", word_count, 0);
    in_valid = 0;

    // Single word, one-cycle latency.
    key_load = 1; key_in = 8'h3C;
    step();
    key_load = 0; in_valid = 1; in_data = 8'hA5;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 8'hE4);
    chk("lat_cnt", word_count, 1);
    out_ready = 1;
    step();
    out_ready = 0;

    // Back-to-back pair with fresh key.
    key_load = 1; key_in = 8'h3C;
    step();
    key_load = 0; in_valid = 1; in_data = 8'hA5;
    step();
    in_data = 8'h00;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("pair_first", out_data, 8'hE4);
    chk("pair_fill", fill_level, 2);
    out_ready = 1;
    step();
`ifdef KEY_ROLL_EN
    exp2 = 8'h27;
`else
    exp2 = 8'h63;
`endif
    @(negedge clk);
    chk("pair_second", out_data, exp2);
    step();
    out_ready = 0;

    // Fill to DEPTH, then hold in_valid against a full FIFO.
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'h11 * i[7:0] + 8'h0F;
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("full_fill", fill_level, 4);
    chk("full_ready", in_ready, 0);
    chk("full_cnt", word_count, 7);
    out_ready = 1;
    step();
    out_ready = 0;
    @(negedge clk);
    chk("pop1_fill", fill_level, 3);
    chk("pop1_ready", in_ready, 1);
    out_ready = 1;
    step(); step(); step();
    out_ready = 0;

    // Steady state at fill 2 with push and pop every cycle.
    in_valid = 1;
    in_data = 8'hC3; step();
    in_data = 8'h7E; step();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h9A ^ (i[7:0] << 3);
      step();
      @(negedge clk);
      chk("rate_fill", fill_level, 2);
    end
    in_valid = 0;
    step(); step();
    out_ready = 0;

    // Key reload coinciding with an accept: that word uses the old key.
    in_valid = 1; in_data = 8'hF0;
    key_load = 1; key_in = 8'hA1;
    step();
    key_load = 0; in_data = 8'h0F;
    step();
    in_valid = 0;

    // Reset with 3 words queued.
    in_valid = 1; in_data = 8'h12;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("pre_rst_fill", fill_level, 3);
    reset = 1;
    step();
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_key", key_valid, 0);
    chk("rst_cnt", word_count, 0);
    reset = 0;

    // Operation resumes after a reload.
    key_load = 1; key_in = 8'h3C;
    step();
    key_load = 0; in_valid = 1; in_data = 8'hA5;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("post_rst_data", out_data, 8'hE4);
    chk("post_rst_cnt", word_count, 1);
    out_ready = 1;
    step(); step();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
